pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives enable/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and selects operand forwarding for the EX stage.
- Handles four cases: load-use stalls, taken-branch flushes, data-memory wait freezes with timeout detection, and stall/flush performance counting.
- Sits between the decode/execute control path and the pipeline registers.

Parameters:
- WAIT_TIMEOUT, 64: consecutive memory-wait cycles after which mem_timeout is raised.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- id_rn  input  4  first source register of the instruction in ID
- id_rm  input  4  second source register of the instruction in ID
- id_uses_rn  input  1  ID instruction reads id_rn
- id_uses_rm  input  1  ID instruction reads id_rm
- ex_rn  input  4  first source register of the instruction in EX
- ex_rm  input  4  second source register of the instruction in EX
- ex_rd  input  4  destination of the instruction in EX
- ex_reg_write  input  1  EX instruction writes a register
- ex_mem_to_reg  input  1  EX instruction is a load
- mem_rd  input  4  destination in MEM
- mem_reg_write  input  1  MEM instruction writes a register
- wb_rd  input  4  destination in WB
- wb_reg_write  input  1  WB instruction writes a register
- ex_branch_taken  input  1  branch resolved taken in EX this cycle
- dmem_req  input  1  MEM stage has an active data-memory access
- dmem_ready  input  1  data memory completes the access this cycle
- pc_en  output  1  PC load enable
- if_id_en  output  1  IF/ID load enable
- if_id_flush  output  1  IF/ID clear to bubble
- id_ex_en  output  1  ID/EX load enable
- id_ex_flush  output  1  ID/EX clear to bubble (all control outputs zero)
- ex_mem_en  output  1  EX/MEM load enable
- mem_wb_en  output  1  MEM/WB load enable
- fwd_a_sel  output  2  EX operand A source: 00 = register file, 01 = WB result, 10 = MEM ALU result
- fwd_b_sel  output  2  same encoding, for operand B
- mem_timeout  output  1  sticky: memory wait exceeded WAIT_TIMEOUT
- stall_count  output  CNT_W  cycles with pc_en=0
- flush_count  output  CNT_W  taken-branch flushes

Behaviour:
- Control outputs are combinational from the current inputs and registered state.
- FSM state, the wait counter, mem_timeout and the performance counters are registered.

Reset:
- While reset=1:
  - all enables are 0; if_id_flush=1 and id_ex_flush=1
  - fwd selects are 00
- On the reset edge: state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0, flush_count=0.
- Reset asserted during MEM_WAIT aborts the wait on that edge.

Condition definitions:
- freeze = dmem_req & ~dmem_ready
- load_use = ex_mem_to_reg & ex_reg_write & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd))

Priority, highest first:
1. freeze:
   - all five enables are 0; no flushes
   - inputs are held by the frozen pipeline
   - a pending branch or load_use is acted on in the first unfrozen cycle.
2. ex_branch_taken:
   - pc_en=1 (the PC loads the target)
   - if_id_flush=1, id_ex_flush=1
   - other enables are 1
   - load_use is ignored, because the ID instruction is wrong-path.
3. load_use:
   - pc_en=0, if_id_en=0, id_ex_flush=1
   - ex_mem_en=1, mem_wb_en=1
   - exactly one bubble is inserted. The next cycle the load is in WB and is forwarded via 01.
4. Otherwise: all enables are 1; no flushes.

Forwarding:
- Operand A:
  - fwd_a_sel=10 if mem_reg_write & mem_rd==ex_rn & mem_rd!=15
  - else 01 if wb_reg_write & wb_rd==ex_rn & wb_rd!=15
  - else 00
- Operand B: identical, using ex_rm.
- MEM takes priority over WB. R15 is never forwarded.
- Forwarding selects are evaluated during freeze as well.

FSM (states RUN, MEM_WAIT):
- RUN -> MEM_WAIT when freeze; wait_cnt is set to 1.
- MEM_WAIT:
  - if dmem_ready=1: return to RUN, wait_cnt=0. Release is combinational, so the pipeline advances in the same cycle.
  - otherwise: wait_cnt increments, saturating at WAIT_TIMEOUT.
  - when wait_cnt reaches WAIT_TIMEOUT, mem_timeout sets and stays 1 until reset. The FSM keeps waiting.
- If dmem_req drops in MEM_WAIT: return to RUN (access cancelled).

Counters:
- stall_count increments on every non-reset cycle with pc_en=0 (freeze or load_use).
- flush_count increments on every non-reset cycle where the branch flush is applied (case 2).
- Both saturate at 2^CNT_W-1 with no wrap.

Test Plan:
- Load-use: EX = load r3 (ex_mem_to_reg=1, ex_reg_write=1, ex_rd=3); ID reads r3 (id_uses_rn=1, id_rn=3) -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, stall_count=1. Next cycle, with wb_rd=3, wb_reg_write=1 and ex_rn=3 -> fwd_a_sel=01.
- Double forward: mem_rd=5, wb_rd=5 (both writing), ex_rm=5 -> fwd_b_sel=10. Same test with mem_rd=15, wb_rd=15 and ex_rm=15 -> fwd_b_sel=00.
- Branch over load-use: ex_branch_taken=1 together with a load_use match -> pc_en=1, if_id_flush=1, id_ex_flush=1, flush_count=1, stall_count unchanged.
- Memory wait: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, enables 1 on the fourth cycle, stall_count=3, FSM back in RUN.
- Timeout: WAIT_TIMEOUT=4, dmem_ready held 0 -> mem_timeout=1 after the 4th wait cycle; it stays 1 after dmem_ready=1 and clears only on reset.
- Reset mid-wait: reset during MEM_WAIT -> next cycle all counters 0, mem_timeout=0, state RUN. While reset=1: pc_en=0, if_id_flush=1, id_ex_flush=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Hazard and sequencing controller for the 5-stage pipeline. Generates the
//   load enables and flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers. Selects EX-stage operand forwarding. Tracks data-memory wait
//   time and raises a sticky timeout. Counts stall and flush cycles.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   id_rn_i/id_rm_i               source registers of the ID instruction
//   id_uses_rn_i/id_uses_rm_i     ID instruction actually reads rn/rm
//   ex_rn_i/ex_rm_i/ex_rd_i       sources/destination of the EX instruction
//   ex_reg_write_i                EX instruction writes a register
//   ex_mem_to_reg_i               EX instruction is a load
//   mem_rd_i/mem_reg_write_i      destination/write flag of MEM instruction
//   wb_rd_i/wb_reg_write_i        destination/write flag of WB instruction
//   ex_branch_taken_i             branch resolved taken in EX this cycle
//   dmem_req_i/dmem_ready_i       data-memory access active / completing
//   pc_en_o .. mem_wb_en_o        pipeline register load enables
//   if_id_flush_o/id_ex_flush_o   clear register to a bubble
//   fwd_a_sel_o/fwd_b_sel_o       00 regfile, 01 WB result, 10 MEM ALU result
//   mem_timeout_o                 sticky: memory wait reached WAIT_TIMEOUT
//   stall_count_o                 saturating count of cycles with pc_en_o=0
//   flush_count_o                 saturating count of taken-branch flushes
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn_i,
  input  logic [3:0]       id_rm_i,
  input  logic             id_uses_rn_i,
  input  logic             id_uses_rm_i,
  input  logic [3:0]       ex_rn_i,
  input  logic [3:0]       ex_rm_i,
  input  logic [3:0]       ex_rd_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_mem_to_reg_i,
  input  logic [3:0]       mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [3:0]       wb_rd_i,
  input  logic             wb_reg_write_i,
  input  logic             ex_branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WCW-1:0]   WAIT_MAX = WCW'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic load_use;
  logic branch_flush;

  assign freeze   = dmem_req_i & ~dmem_ready_i;
  assign load_use = ex_mem_to_reg_i & ex_reg_write_i &
                    ((id_uses_rn_i & (id_rn_i == ex_rd_i)) |
                     (id_uses_rm_i & (id_rm_i == ex_rd_i)));
  // A branch seen during a freeze is held by the frozen pipeline and only
  // takes effect in the first unfrozen cycle.
  assign branch_flush = ~reset & ~freeze & ex_branch_taken_i;

  // Pipeline register controls, in priority order: reset, freeze, taken
  // branch (wrong-path ID instruction makes load_use irrelevant), load_use.
  // On load_use the ID/EX register loads the flushed bubble while IF/ID and
  // the PC hold, so exactly one bubble enters EX.
  always_comb begin
    pc_en_o       = 1'b1;
    if_id_en_o    = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_en_o    = 1'b1;
    id_ex_flush_o = 1'b0;
    ex_mem_en_o   = 1'b1;
    mem_wb_en_o   = 1'b1;
    if (reset) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_en_o    = 1'b0;
      ex_mem_en_o   = 1'b0;
      mem_wb_en_o   = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (freeze) begin
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
      mem_wb_en_o = 1'b0;
    end else if (ex_branch_taken_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  // Forwarding: the younger MEM result wins over WB; R15 is never forwarded.
  // Evaluated regardless of freeze so the held EX operands stay correct.
  always_comb begin
    fwd_a_sel_o = 2'b00;
    fwd_b_sel_o = 2'b00;
    if (!reset) begin
      if (mem_reg_write_i && mem_rd_i == ex_rn_i && mem_rd_i != 4'd15)
        fwd_a_sel_o = 2'b10;
      else if (wb_reg_write_i && wb_rd_i == ex_rn_i && wb_rd_i != 4'd15)
        fwd_a_sel_o = 2'b01;
      if (mem_reg_write_i && mem_rd_i == ex_rm_i && mem_rd_i != 4'd15)
        fwd_b_sel_o = 2'b10;
      else if (wb_reg_write_i && wb_rd_i == ex_rm_i && wb_rd_i != 4'd15)
        fwd_b_sel_o = 2'b01;
    end
  end

  // Wait-tracking FSM and counters. The first frozen cycle counts as wait
  // cycle 1, so the timeout flag rises on the edge that ends wait cycle
  // WAIT_TIMEOUT. Release back to RUN happens on ready or on a dropped
  // request (cancelled access).
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (!dmem_req_i || dmem_ready_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == WAIT_MAX);
    if (!pc_en_o && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch_flush && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign mem_timeout_o = mem_timeout_q;
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule
